// File: rtl/mips_pkg.sv
// Shared front-end definitions: datapath width defaults, reset PC, fetch step and NOP.
// Also holds the push/pop classification used by the instruction queue.
package mips_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          INST_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam int          PC_STEP_DEF  = 4;
  localparam logic [31:0] INST_NOP     = 32'h0;

  typedef enum logic [1:0] {
    FQ_HOLD = 2'b00,
    FQ_POP  = 2'b01,
    FQ_PUSH = 2'b10,
    FQ_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    fifo_op_e op;
    case ({push, pop})
      2'b10:   op = FQ_PUSH;
      2'b01:   op = FQ_POP;
      2'b11:   op = FQ_BOTH;
      default: op = FQ_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with flush; head is read combinationally from the storage.
// Control state is reset; the storage array is data only and is never reset.
module sync_fifo
  import mips_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow: a push into a full queue needs a same-cycle pop.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (fifo_op(push_ok, pop_ok))
        FQ_PUSH: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
        end
        FQ_POP: begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          count_d  = count_q - CNT_W'(1);
        end
        FQ_BOTH: begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: owns the PC, reads the async ROM and queues {pc,inst} pairs
// toward ID with a valid/ready handshake; redirects reload the PC and flush the queue.
module fetch_queue_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                PC_STEP  = PC_STEP_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          rom_pc,
  input  logic [INST_W-1:0]          rom_inst,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       id_valid,
  input  logic                       id_ready,
  output logic [ADDR_W-1:0]          id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int ENTRY_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               fetch;
  logic               pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_empty;
  logic               fifo_full;

  assign rom_pc   = pc_q;
  assign id_valid = !fifo_empty;
  assign pop      = id_valid && id_ready;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign fetch    = !redirect_valid && (!fifo_full || pop);

  assign id_pc   = id_valid ? fifo_head[ENTRY_W-1 -: ADDR_W] : '0;
  assign id_inst = id_valid ? fifo_head[INST_W-1:0] : INST_W'(INST_NOP);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (fetch) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // A pop coinciding with a redirect still completes the handshake; the flush discards it.
  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc_q, rom_inst}),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (q_count)
  );

endmodule
